rng_scheduler: RTL and testbench
================================

RNG_SCHEDULER -- requirements
Module: rng_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the random stream, range 2..8.
REQ-002 Parameter WARMUP, default 16: LFSR advances discarded after each seed load, range 1..255.
REQ-003 i_Clk  input  1  clock; all state changes occur on its rising edge.
REQ-004 i_Rst  input  1  synchronous, active-high reset.
REQ-005 i_Seed_Data  input  32  seed value, sampled in the LOAD state.
REQ-006 i_Reseed  input  1  single-cycle pulse requesting a reload of i_Seed_Data.
REQ-007 i_Req  input  NUM_REQ  level requests; bit i high means requester i wants one word this cycle.
REQ-008 o_Gnt  output  NUM_REQ  one-hot grant, registered, high for one cycle per word delivered.
REQ-009 o_Data  output  32  random word belonging to the current o_Gnt, registered.
REQ-010 o_Valid  output  1  high exactly when o_Gnt is non-zero.
REQ-011 o_Ready  output  1  high while in the SERVE state.
REQ-012 o_Period_Done  output  1  one-cycle pulse when the LFSR state equals the latched seed after a SERVE advance.

Function
REQ-013 The internal 32-bit LFSR SHALL step as: next = {lfsr[30:0], fb}, where fb = NOT(lfsr[31] XOR lfsr[21] XOR lfsr[1] XOR lfsr[0]).
REQ-014 States SHALL be LOAD, WARM and SERVE; 2-bit state encoding.
REQ-015 LOAD SHALL latch the effective seed into both the LFSR and the seed register, clear the warm-up counter, and go to WARM on the next cycle.
REQ-016 Effective seed = i_Seed_Data, except 32'hFFFFFFFF (the XNOR lock-up state), which SHALL be replaced by 32'h00000001.
REQ-017 WARM SHALL advance the LFSR every cycle and increment an 8-bit counter; after WARMUP advances it SHALL go to SERVE.
REQ-018 SERVE SHALL advance the LFSR only in cycles where a grant is issued, with at most one advance per cycle.
REQ-019 Arbitration SHALL be round-robin: search starts at the requester after the last granted one, wrapping NUM_REQ-1 -> 0; the pointer after reset is such that requester 0 has top priority.
REQ-020 Latency: if i_Req is sampled non-zero in SERVE at edge t, o_Gnt/o_Valid/o_Data SHALL be valid in the cycle following t; o_Data = LFSR value before that advance.
REQ-021 Each delivered word SHALL be distinct consecutive LFSR state; throughput is one word per cycle.
REQ-022 Outside SERVE, o_Gnt, o_Valid SHALL be 0 the next cycle; o_Data SHALL hold its last value.
REQ-023 i_Reseed high in any state SHALL force LOAD next cycle, suppress any grant for that cycle, and keep the round-robin pointer.
REQ-024 i_Reseed and i_Req asserted together: reseed wins, no grant issued.
REQ-025 o_Period_Done SHALL be registered; it is never asserted in LOAD or WARM.

Reset
REQ-026 i_Rst SHALL take priority over i_Reseed and all other inputs.
REQ-027 On i_Rst: state=LOAD, LFSR=32'h1, seed register=32'h1, counter=0, pointer=requester 0 top priority.
REQ-028 On i_Rst: o_Gnt=0, o_Valid=0, o_Data=0, o_Ready=0, o_Period_Done=0, all in the cycle after the reset edge.
REQ-029 Reset asserted mid-WARM or mid-SERVE SHALL abandon the sequence with no partial grant.

Verification
REQ-030 WARMUP=2, seed 32'h1, reset released, i_Req=4'b0001 held -> o_Ready rises 3 cycles after release; o_Data = 0x4, 0x9, 0x12, 0x24 on consecutive cycles, each with o_Gnt=0001.
REQ-031 In SERVE, i_Req=4'b1111 held -> o_Gnt = 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with o_Data advancing once per cycle.
REQ-032 Seed 1, WARMUP=2, two words delivered, then i_Reseed pulsed with i_Req held -> no grant in the cycle after the pulse; o_Ready low for 3 cycles; the next o_Data = 0x4.
REQ-033 i_Seed_Data=32'hFFFFFFFF -> output sequence identical to REQ-030.
REQ-034 i_Rst asserted during WARM or during a stream of grants -> all outputs zero the next cycle; the REQ-030 sequence restarts after release.

Source files
------------

// File: rtl/rng_scheduler.sv
// Round-robin distributor of a 32-bit XNOR-LFSR stream across NUM_REQ requesters.
// The LFSR is seeded, warmed up for WARMUP steps, then advanced once per granted word.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_LOAD  | latch effective seed into LFSR and seed register, clear count
// ST_WARM  | advance LFSR every cycle, discarding WARMUP words
// ST_SERVE | grant one requester per cycle, one LFSR advance per grant
module rng_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WARMUP  = 16
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [31:0]        i_Seed_Data,
    input  logic               i_Reseed,
    input  logic [NUM_REQ-1:0] i_Req,
    output logic [NUM_REQ-1:0] o_Gnt,
    output logic [31:0]        o_Data,
    output logic               o_Valid,
    output logic               o_Ready,
    output logic               o_Period_Done
);

    localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0]  PTR_RST   = PTR_W'(NUM_REQ - 1);
    localparam logic [7:0]        WARM_LAST = 8'(WARMUP - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WARM  = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        lfsr;
    logic [31:0]        lfsr_nxt;
    logic [31:0]        seed_r;
    logic [31:0]        eff_seed;
    logic [7:0]         warm_cnt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;
    logic               fire;
    int                 scan;
    logic [PTR_W-1:0]   scan_idx;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], ~(v[31] ^ v[21] ^ v[1] ^ v[0])};
    endfunction

    assign lfsr_nxt = lfsr_step(lfsr);

    // All-ones is the XNOR lock-up state, so it is never allowed into the LFSR.
    assign eff_seed = (i_Seed_Data == 32'hFFFF_FFFF) ? 32'h0000_0001 : i_Seed_Data;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr;
        scan       = 0;
        scan_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan = int'(ptr) + k;
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            scan_idx = PTR_W'(scan);
            if (!pick_found && i_Req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        case (state)
            ST_LOAD: begin
                state_nxt = ST_WARM;
            end
            ST_WARM: begin
                if (warm_cnt == WARM_LAST) begin
                    state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                fire = pick_found;
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
        if (i_Reseed) begin
            state_nxt = ST_LOAD;
            fire      = 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            lfsr          <= 32'h0000_0001;
            seed_r        <= 32'h0000_0001;
            warm_cnt      <= '0;
            ptr           <= PTR_RST;
            o_Gnt         <= '0;
            o_Data        <= '0;
            o_Period_Done <= 1'b0;
        end else begin
            o_Gnt         <= fire ? (ONE_HOT0 << pick_idx) : '0;
            o_Period_Done <= 1'b0;
            case (state)
                ST_LOAD: begin
                    lfsr     <= eff_seed;
                    seed_r   <= eff_seed;
                    warm_cnt <= '0;
                end
                ST_WARM: begin
                    if (!i_Reseed) begin
                        lfsr     <= lfsr_nxt;
                        warm_cnt <= warm_cnt + 8'd1;
                    end
                end
                ST_SERVE: begin
                    if (fire) begin
                        o_Data        <= lfsr;
                        lfsr          <= lfsr_nxt;
                        ptr           <= pick_idx;
                        o_Period_Done <= (lfsr_nxt == seed_r);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_Valid = |o_Gnt;
    assign o_Ready = (state == ST_SERVE);

endmodule

// File: tb/tb_rng_scheduler.sv
// Directed bench for rng_scheduler (NUM_REQ=4, WARMUP=2): cycle table plus reseed/idle sequences.
module tb_rng_scheduler;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic [31:0] i_Seed_Data;
    logic        i_Reseed;
    logic [3:0]  i_Req;
    logic [3:0]  o_Gnt;
    logic [31:0] o_Data;
    logic        o_Valid;
    logic        o_Ready;
    logic        o_Period_Done;

    rng_scheduler #(.NUM_REQ(4), .WARMUP(2)) dut (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_Seed_Data   (i_Seed_Data),
        .i_Reseed      (i_Reseed),
        .i_Req         (i_Req),
        .o_Gnt         (o_Gnt),
        .o_Data        (o_Data),
        .o_Valid       (o_Valid),
        .o_Ready       (o_Ready),
        .o_Period_Done (o_Period_Done)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic        rst;
        logic        reseed;
        logic [3:0]  req;
        logic [31:0] seed;
        logic [3:0]  gnt;
        logic [31:0] data;
        logic        ready;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   row      = 0;

    task automatic add(input logic rst, input logic reseed, input logic [3:0] req,
                       input logic [31:0] seed, input logic [3:0] gnt,
                       input logic [31:0] data, input logic ready);
        vec_t v;
        v.rst = rst; v.reseed = reseed; v.req = req; v.seed = seed;
        v.gnt = gnt; v.data = data; v.ready = ready;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=0x%0h required=0x%0h", name, row, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic check_outputs(input logic [3:0] gnt, input logic [31:0] data, input logic ready);
        check("gnt",         32'(o_Gnt),         32'(gnt));
        check("valid",       32'(o_Valid),       32'(|gnt));
        check("data",        o_Data,             data);
        check("ready",       32'(o_Ready),       32'(ready));
        check("period_done", 32'(o_Period_Done), 32'd0);
    endtask

    initial begin
        int n;
        i_Rst = 1'b1; i_Reseed = 1'b0; i_Req = 4'b0000; i_Seed_Data = 32'h1;

        // rst reseed req     seed          gnt      data          ready
        add(1, 0, 4'b0001, 32'h1,        4'b0000, 32'h0,      0);
        add(0, 0, 4'b0001, 32'h1,        4'b0000, 32'h0,      0);
        add(0, 0, 4'b0001, 32'h1,        4'b0000, 32'h0,      0);
        add(0, 0, 4'b0001, 32'h1,        4'b0000, 32'h0,      1);
        add(0, 0, 4'b0001, 32'h1,        4'b0001, 32'h4,      1);
        add(0, 0, 4'b0001, 32'h1,        4'b0001, 32'h9,      1);
        add(0, 0, 4'b0001, 32'h1,        4'b0001, 32'h12,     1);
        add(0, 0, 4'b0001, 32'h1,        4'b0001, 32'h24,     1);
        add(0, 0, 4'b0000, 32'h1,        4'b0000, 32'h24,     1);
        add(0, 0, 4'b1111, 32'h1,        4'b0010, 32'h49,     1);
        add(0, 0, 4'b1111, 32'h1,        4'b0100, 32'h92,     1);
        add(0, 0, 4'b1111, 32'h1,        4'b1000, 32'h124,    1);
        add(0, 0, 4'b1111, 32'h1,        4'b0001, 32'h249,    1);
        add(0, 0, 4'b1111, 32'h1,        4'b0010, 32'h492,    1);
        add(0, 0, 4'b1001, 32'h1,        4'b1000, 32'h924,    1);
        add(0, 0, 4'b1001, 32'h1,        4'b0001, 32'h1249,   1);
        add(0, 0, 4'b0110, 32'h1,        4'b0010, 32'h2492,   1);
        // reseed with requests pending; pointer must survive
        add(0, 1, 4'b1111, 32'h1,        4'b0000, 32'h2492,   0);
        add(0, 0, 4'b1111, 32'h1,        4'b0000, 32'h2492,   0);
        add(0, 0, 4'b1111, 32'h1,        4'b0000, 32'h2492,   0);
        add(0, 0, 4'b1111, 32'h1,        4'b0000, 32'h2492,   1);
        add(0, 0, 4'b1111, 32'h1,        4'b0100, 32'h4,      1);
        add(0, 0, 4'b1111, 32'h1,        4'b1000, 32'h9,      1);
        // lock-up seed substituted by 1
        add(0, 1, 4'b0000, 32'hFFFFFFFF, 4'b0000, 32'h9,      0);
        add(0, 0, 4'b0000, 32'hFFFFFFFF, 4'b0000, 32'h9,      0);
        add(0, 0, 4'b0000, 32'hFFFFFFFF, 4'b0000, 32'h9,      0);
        add(0, 0, 4'b0000, 32'hFFFFFFFF, 4'b0000, 32'h9,      1);
        add(0, 0, 4'b0001, 32'hFFFFFFFF, 4'b0001, 32'h4,      1);
        add(0, 0, 4'b0001, 32'hFFFFFFFF, 4'b0001, 32'h9,      1);
        // seed 0: first warm step gives 1, second gives 2
        add(0, 1, 4'b0000, 32'h0,        4'b0000, 32'h9,      0);
        add(0, 0, 4'b0000, 32'h0,        4'b0000, 32'h9,      0);
        add(0, 0, 4'b0000, 32'h0,        4'b0000, 32'h9,      0);
        add(0, 0, 4'b0000, 32'h0,        4'b0000, 32'h9,      1);
        add(0, 0, 4'b0001, 32'h0,        4'b0001, 32'h2,      1);
        add(0, 0, 4'b0001, 32'h0,        4'b0001, 32'h4,      1);
        // reset mid-SERVE, then mid-WARM together with reseed
        add(1, 0, 4'b1111, 32'h1,        4'b0000, 32'h0,      0);
        add(0, 0, 4'b0001, 32'h1,        4'b0000, 32'h0,      0);
        add(0, 0, 4'b0001, 32'h1,        4'b0000, 32'h0,      0);
        add(1, 1, 4'b0001, 32'h1,        4'b0000, 32'h0,      0);
        add(0, 0, 4'b0001, 32'h1,        4'b0000, 32'h0,      0);
        add(0, 0, 4'b0001, 32'h1,        4'b0000, 32'h0,      0);
        add(0, 0, 4'b0001, 32'h1,        4'b0000, 32'h0,      1);
        add(0, 0, 4'b0001, 32'h1,        4'b0001, 32'h4,      1);
        add(0, 0, 4'b0001, 32'h1,        4'b0001, 32'h9,      1);

        for (int i = 0; i < vecs.size(); i++) begin
            row         = i;
            i_Rst       = vecs[i].rst;
            i_Reseed    = vecs[i].reseed;
            i_Req       = vecs[i].req;
            i_Seed_Data = vecs[i].seed;
            step();
            check_outputs(vecs[i].gnt, vecs[i].data, vecs[i].ready);
        end

        // Reseed again in the middle of WARM: warm-up restarts from the fresh seed.
        row = 1000;
        i_Rst = 1'b0; i_Seed_Data = 32'h1; i_Req = 4'b0001;
        i_Reseed = 1'b1; step();
        check("reseed_no_gnt", 32'(o_Gnt), 32'd0);
        i_Reseed = 1'b0; step(); step();
        check("in_warm", 32'(o_Ready), 32'd0);
        i_Reseed = 1'b1; step();
        check("rewarm_ready_low", 32'(o_Ready), 32'd0);
        i_Reseed = 1'b0;
        n = 0;
        while (!o_Ready && n < 10) begin
            step();
            n++;
            if (!o_Ready) check("warm_gnt_low", 32'(o_Gnt), 32'd0);
        end
        check("rewarm_cycles", 32'(n), 32'd3);
        step();
        check("rewarm_gnt", 32'(o_Gnt), 32'b0001);
        check("rewarm_data", o_Data, 32'h4);

        // Idle SERVE holds data with valid low, then a single requester resumes the stream.
        row = 1001;
        i_Req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            step();
            check_outputs(4'b0000, 32'h4, 1'b1);
        end
        i_Req = 4'b0010; step();
        check_outputs(4'b0010, 32'h9, 1'b1);
        i_Req = 4'b0010; step();
        check_outputs(4'b0010, 32'h12, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
